// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared arbiter state encoding and UART sizing constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_byte_w = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    // A full 8N1 frame is 10 bit times; 12 leaves margin for a slow TX.
    function automatic int default_timeout(input int clks_per_bit);
        return 12 * clks_per_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector, searching upward from ptr+1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    int w_idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        w_idx = 0;
        for (int off = 1; off <= N; off++) begin
            w_idx = (int'(ptr) + off) % N;
            if (!any && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                id           = ID_W'(w_idx);
                any          = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin share of one UART TX among NUM_REQ byte sources.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = default_timeout(CLKS_PER_BIT),
    parameter int GAP_CLKS     = 0,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [c_byte_w*NUM_REQ-1:0] i_req_byte,
    input  logic [NUM_REQ-1:0]          i_req_last,
    input  logic                        i_lock_en,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_tx_dv,
    output logic [c_byte_w-1:0]         o_tx_byte,
    input  logic                        i_tx_done,
    output logic [ID_W-1:0]             o_grant_id,
    output logic                        o_busy,
    output logic                        o_timeout
);

    localparam int c_wd_w     = $clog2(TIMEOUT_CLKS);
    localparam int c_gap_w    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int c_gap_last = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                r_lock;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [c_byte_w-1:0] r_tx_byte;
    logic [c_wd_w-1:0]   r_wd_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;

    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [ID_W-1:0]     w_pick_id;
    logic                w_pick_any;
    logic                w_accept;
    logic [c_byte_w-1:0] w_bytes [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
        assign w_bytes[k] = i_req_byte[k*c_byte_w +: c_byte_w];
    end

    // While a packet is locked, only the holder of the last grant may compete.
    assign w_elig = r_lock ? (i_req_valid & (NUM_REQ'(1) << r_grant_id))
                           : i_req_valid;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (w_elig),
        .ptr   (r_ptr),
        .grant (w_pick_grant),
        .id    (w_pick_id),
        .any   (w_pick_any)
    );

    assign o_tx_byte  = r_tx_byte;
    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_req_ready = '0;
        o_tx_dv     = 1'b0;
        o_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_accept    = 1'b1;
                    o_req_ready = w_pick_grant;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_tx_dv     = 1'b1;
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the terminal count still completes the byte.
                if (i_tx_done) begin
                    w_state_nxt = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
                end else if (r_wd_cnt == c_wd_w'(TIMEOUT_CLKS - 1)) begin
                    o_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_w'(c_gap_last)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_lock     <= 1'b0;
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_tx_byte  <= '0;
            r_wd_cnt   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_byte  <= w_bytes[w_pick_id];
                r_grant_id <= w_pick_id;
                r_ptr      <= w_pick_id;
                if (i_req_last[w_pick_id]) begin
                    r_lock <= 1'b0;
                end else if (i_lock_en) begin
                    r_lock <= 1'b1;
                end
            end
            if (o_timeout) begin
                r_lock <= 1'b0;
            end
            if (r_state == ST_WAIT_DONE) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench: arbitration table, lock, timeout, gap, reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a_valid, b_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_last;
    logic        lock_en;
    logic        a_done, b_done;

    logic [3:0]  a_ready, b_ready;
    logic        a_dv, b_dv;
    logic [7:0]  a_byte, b_byte;
    logic [1:0]  a_id, b_id;
    logic        a_busy, b_busy;
    logic        a_timeout, b_timeout;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q [$];
    logic [9:0] obs_q [$];

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .TIMEOUT_CLKS (20),
        .GAP_CLKS     (0)
    ) u_dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (a_valid),
        .i_req_byte  (req_byte),
        .i_req_last  (req_last),
        .i_lock_en   (lock_en),
        .o_req_ready (a_ready),
        .o_tx_dv     (a_dv),
        .o_tx_byte   (a_byte),
        .i_tx_done   (a_done),
        .o_grant_id  (a_id),
        .o_busy      (a_busy),
        .o_timeout   (a_timeout)
    );

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .TIMEOUT_CLKS (20),
        .GAP_CLKS     (5)
    ) u_dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (b_valid),
        .i_req_byte  (req_byte),
        .i_req_last  (req_last),
        .i_lock_en   (lock_en),
        .o_req_ready (b_ready),
        .o_tx_dv     (b_dv),
        .o_tx_byte   (b_byte),
        .i_tx_done   (b_done),
        .o_grant_id  (b_id),
        .o_busy      (b_busy),
        .o_timeout   (b_timeout)
    );

    // Every issued byte on DUT A is captured for the scoreboard.
    always @(negedge clk) begin
        if (a_dv === 1'b1) obs_q.push_back({a_byte, a_id});
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Entered at an IDLE cycle with inputs already driven; leaves at the next IDLE cycle.
    task automatic xact_a(input logic [3:0] exp_rdy, input logic [1:0] exp_id);
        logic [7:0] eb;
        eb = req_byte[8*int'(exp_id) +: 8];
        #1;
        chk("accept_ready", {28'd0, a_ready}, {28'd0, exp_rdy});
        exp_q.push_back({eb, exp_id});
        tick();
        chk("dv_latency", {31'd0, a_dv}, 32'd1);
        tick();
        tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
    endtask

    task automatic sb_drain(input string tag);
        while (exp_q.size() > 0) begin
            if (obs_q.size() == 0) begin
                chk({tag, "_missing_byte"}, 32'd0, 32'd1);
                exp_q.delete();
            end else begin
                chk({tag, "_order"}, {22'd0, obs_q.pop_front()}, {22'd0, exp_q.pop_front()});
            end
        end
        chk({tag, "_extra_bytes"}, obs_q.size(), 32'd0);
        obs_q.delete();
    endtask

    initial begin
        int n;
        int gap_k;
        logic saw_to;

        vecs[0] = '{4'b1111, 4'b0001, 2'd0};
        vecs[1] = '{4'b1111, 4'b0010, 2'd1};
        vecs[2] = '{4'b1001, 4'b1000, 2'd3};
        vecs[3] = '{4'b0110, 4'b0010, 2'd1};
        vecs[4] = '{4'b0001, 4'b0001, 2'd0};
        vecs[5] = '{4'b1100, 4'b0100, 2'd2};
        vecs[6] = '{4'b0100, 4'b0100, 2'd2};
        vecs[7] = '{4'b1011, 4'b1000, 2'd3};

        rst      = 1'b0;
        a_valid  = '0;
        b_valid  = '0;
        req_byte = '0;
        req_last = '0;
        lock_en  = 1'b0;
        a_done   = 1'b0;
        b_done   = 1'b0;

        do_reset();
        #1;
        chk("rst_ready",   {28'd0, a_ready}, 32'd0);
        chk("rst_dv",      {31'd0, a_dv}, 32'd0);
        chk("rst_byte",    {24'd0, a_byte}, 32'd0);
        chk("rst_id",      {30'd0, a_id}, 32'd0);
        chk("rst_busy",    {31'd0, a_busy}, 32'd0);
        chk("rst_timeout", {31'd0, a_timeout}, 32'd0);

        // Single request from requester 2, done ten cycles after dv.
        a_valid  = 4'b0100;
        req_byte = 32'h00A6_0000;
        #1;
        chk("single_ready", {28'd0, a_ready}, 32'b0100);
        exp_q.push_back({8'hA6, 2'd2});
        tick();
        a_valid = '0;
        #1;
        chk("single_dv",    {31'd0, a_dv}, 32'd1);
        chk("single_byte",  {24'd0, a_byte}, 32'hA6);
        chk("single_id",    {30'd0, a_id}, 32'd2);
        chk("single_busy",  {31'd0, a_busy}, 32'd1);
        chk("single_ready_low", {28'd0, a_ready}, 32'd0);
        repeat (10) tick();
        a_done = 1'b1;
        #1;
        chk("single_busy_at_done", {31'd0, a_busy}, 32'd1);
        tick();
        a_done = 1'b0;
        chk("single_busy_after", {31'd0, a_busy}, 32'd0);
        sb_drain("single");

        // Table of arbitration vectors from a fresh pointer.
        do_reset();
        req_byte = 32'h4433_2211;
        req_last = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            a_valid = vecs[i].valid;
            xact_a(vecs[i].exp_ready, vecs[i].exp_id);
        end
        a_valid = '0;
        sb_drain("table");

        // Fairness with all requesters continuously valid.
        do_reset();
        a_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({req_byte[8*(i%4) +: 8], 2'(i % 4)});
            n = 0;
            while (a_dv !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("fair_dv_seen", {31'd0, a_dv}, 32'd1);
            tick();
            tick();
            a_done = 1'b1;
            tick();
            a_done = 1'b0;
        end
        a_valid = '0;
        sb_drain("fair");

        // Packet lock: requester 1 holds the grant for three bytes over requester 3.
        lock_en  = 1'b1;
        req_last = 4'b0000;
        a_valid  = 4'b1010;
        req_byte = 32'h3C00_A100;
        xact_a(4'b0010, 2'd1);
        req_byte = 32'h3C00_A200;
        xact_a(4'b0010, 2'd1);
        req_byte = 32'h3C00_A300;
        req_last = 4'b0010;
        xact_a(4'b0010, 2'd1);
        req_last = 4'b0000;
        a_valid  = 4'b1000;
        xact_a(4'b1000, 2'd3);
        sb_drain("lock");

        // Watchdog: requester 3 is locked, no done arrives.
        req_byte = 32'h5A00_0077;
        #1;
        chk("to_ready", {28'd0, a_ready}, 32'b1000);
        exp_q.push_back({8'h5A, 2'd3});
        tick();
        a_valid = 4'b0001;
        chk("to_dv", {31'd0, a_dv}, 32'd1);
        repeat (19) tick();
        chk("to_early", {31'd0, a_timeout}, 32'd0);
        tick();
        chk("to_pulse", {31'd0, a_timeout}, 32'd1);
        tick();
        chk("to_pulse_width", {31'd0, a_timeout}, 32'd0);
        chk("to_lock_cleared", {28'd0, a_ready}, 32'b0001);
        lock_en = 1'b0;
        xact_a(4'b0001, 2'd0);
        sb_drain("timeout");

        // Reset during WAIT_DONE.
        req_byte = 32'h4433_2211;
        a_valid  = 4'b1111;
        #1;
        chk("rstw_ready", {28'd0, a_ready}, 32'b0010);
        tick();
        tick();
        chk("rstw_busy_before", {31'd0, a_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        a_valid = '0;
        #1;
        chk("rstw_ready0", {28'd0, a_ready}, 32'd0);
        chk("rstw_dv0",    {31'd0, a_dv}, 32'd0);
        chk("rstw_byte0",  {24'd0, a_byte}, 32'd0);
        chk("rstw_id0",    {30'd0, a_id}, 32'd0);
        chk("rstw_busy0",  {31'd0, a_busy}, 32'd0);
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("rstw_stale_done_busy", {31'd0, a_busy}, 32'd0);
        tick();
        chk("rstw_no_dv", {31'd0, a_dv}, 32'd0);
        obs_q.delete();
        a_valid = 4'b1111;
        xact_a(4'b0001, 2'd0);
        a_valid = '0;
        sb_drain("rstw");

        // Gap instance: done on the terminal count, then a 5-cycle gap.
        b_valid  = 4'b0100;
        req_byte = 32'h00B2_0000;
        #1;
        chk("gap_ready", {28'd0, b_ready}, 32'b0100);
        tick();
        chk("gap_dv",   {31'd0, b_dv}, 32'd1);
        chk("gap_byte", {24'd0, b_byte}, 32'hB2);
        repeat (20) tick();
        b_done = 1'b1;
        #1;
        chk("gap_collision_no_timeout", {31'd0, b_timeout}, 32'd0);
        tick();
        b_done = 1'b0;
        chk("gap_busy", {31'd0, b_busy}, 32'd1);
        gap_k  = 0;
        saw_to = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (b_timeout === 1'b1) saw_to = 1'b1;
            if (b_dv === 1'b1) begin
                gap_k = k;
                break;
            end
            tick();
        end
        chk("gap_next_dv_delay", gap_k, 32'd7);
        chk("gap_no_timeout", {31'd0, saw_to}, 32'd0);
        b_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
